// File: rtl/gpio_rx_deframer.sv
// rtl/gpio_rx_deframer.sv - serial GPIO receive deframer with parity/framing checks and 2-entry output buffer
module gpio_rx_deframer #(
  parameter int SYNC_STAGES = 2,
  parameter int BUF_DEPTH   = 2
) (
  input  logic       rclk,
  input  logic       rrst_n,
  input  logic       enable,
  input  logic       gpio_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow,
  input  logic       clr_status,
  output logic [7:0] err_count,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic [1:0] FULL_OCC = 2'(BUF_DEPTH);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_t state_q, state_d;
  logic [2:0] bitcnt_q;
  logic [7:0] shreg_q;
  logic       par_q;

  logic       shift_en, par_en, stop_en;
  logic       par_ok;

  // Frame outcome, registered at the STOP edge and consumed one edge later
  logic       push_q, perr_q, ferr_q;
  logic [7:0] byte_q;

  logic [7:0] tail_data_q;
  logic       tail_valid_q;
  logic [1:0] occ;
  logic       full, pop, drop, err_evt;

  assign s = sync_q[SYNC_STAGES-1];

  // Input synchronizer; the pin is asynchronous to rclk
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
    end
  end

  // FSM state register
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: disabling the receiver abandons any partial frame
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (s) state_d = DATA;
        DATA:    if (bitcnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: datapath strobes, all suppressed while disabled
  always_comb begin
    busy     = (state_q != IDLE);
    shift_en = enable && (state_q == DATA);
    par_en   = enable && (state_q == PARITY);
    stop_en  = enable && (state_q == STOP);
  end

  // Bit counter and shift register; MSB arrives first so D7 lands in bit 7
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      bitcnt_q <= 3'd0;
      shreg_q  <= 8'd0;
      par_q    <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        bitcnt_q <= 3'd0;
      end else if (shift_en) begin
        bitcnt_q <= bitcnt_q + 3'd1;
      end
      if (shift_en) begin
        shreg_q <= {shreg_q[6:0], s};
      end
      if (par_en) begin
        par_q <= s;
      end
    end
  end

  assign par_ok = ~^{shreg_q, par_q};

  // Stop-bit evaluation; a high stop bit outranks a parity error
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      push_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      byte_q <= 8'd0;
    end else begin
      push_q <= stop_en && !s && par_ok;
      perr_q <= stop_en && !s && !par_ok;
      ferr_q <= stop_en && s;
      if (stop_en) begin
        byte_q <= shreg_q;
      end
    end
  end

  // Error pulses, one cycle each
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      parity_err <= perr_q;
      frame_err  <= ferr_q;
    end
  end

  assign occ     = {1'b0, rx_valid} + {1'b0, tail_valid_q};
  assign full    = (occ == FULL_OCC);
  assign pop     = rx_valid && rx_ready;
  assign drop    = push_q && full && !pop;
  assign err_evt = perr_q || ferr_q;

  // Output buffer: rx_data/rx_valid is the head register, tail holds the second entry
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rx_data      <= 8'd0;
      rx_valid     <= 1'b0;
      tail_data_q  <= 8'd0;
      tail_valid_q <= 1'b0;
    end else begin
      case ({pop, push_q})
        2'b11: begin
          if (tail_valid_q) begin
            rx_data     <= tail_data_q;
            tail_data_q <= byte_q;
          end else begin
            rx_data <= byte_q;
          end
        end
        2'b10: begin
          rx_valid     <= tail_valid_q;
          if (tail_valid_q) begin
            rx_data <= tail_data_q;
          end
          tail_valid_q <= 1'b0;
        end
        2'b01: begin
          if (!rx_valid) begin
            rx_data  <= byte_q;
            rx_valid <= 1'b1;
          end else if (!tail_valid_q) begin
            tail_data_q  <= byte_q;
            tail_valid_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Sticky overflow; a drop coinciding with clr_status still leaves it set
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      overflow <= 1'b0;
    end else if (clr_status) begin
      overflow <= drop;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  // Saturating error counter; an error coinciding with clr_status counts as 1
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      err_count <= 8'd0;
    end else if (clr_status) begin
      err_count <= err_evt ? 8'd1 : 8'd0;
    end else if (err_evt && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_gpio_rx_deframer.sv
// tb/tb_gpio_rx_deframer.sv - scoreboard testbench for gpio_rx_deframer
module tb_gpio_rx_deframer;

  logic       rclk;
  logic       rrst_n;
  logic       enable;
  logic       gpio_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;
  logic       clr_status;
  logic [7:0] err_count;
  logic       busy;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_bytes[$];
  logic [1:0] exp_errs[$];   // {parity_err, frame_err}
  int         exp_err_cnt = 0;
  logic       exp_ovf = 1'b0;

  gpio_rx_deframer #(.SYNC_STAGES(2), .BUF_DEPTH(2)) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .enable     (enable),
    .gpio_in    (gpio_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .clr_status (clr_status),
    .err_count  (err_count),
    .busy       (busy)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    gpio_in = b;
    tick();
  endtask

  // Reference model: classify a frame from its raw bits
  task automatic model_frame(input logic [7:0] d, input logic p, input logic stop_bit,
                             input bit coinc_pop);
    int ones;
    ones = $countones(d) + int'(p);
    if (stop_bit) begin
      exp_errs.push_back(2'b01);
      if (exp_err_cnt < 255) exp_err_cnt++;
    end else if ((ones % 2) != 0) begin
      exp_errs.push_back(2'b10);
      if (exp_err_cnt < 255) exp_err_cnt++;
    end else if (!rx_ready && !coinc_pop && exp_bytes.size() >= 2) begin
      exp_ovf = 1'b1;
    end else begin
      exp_bytes.push_back(d);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pflip, input logic stop_bit,
                            input bit coinc_pop);
    logic p;
    p = (^d) ^ pflip;
    send_bit(1'b1);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(p);
    send_bit(stop_bit);
    gpio_in = 1'b0;
    model_frame(d, p, stop_bit, coinc_pop);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: compare every accepted byte and every error pulse against the scoreboard
  always @(negedge rclk) begin
    if (rrst_n) begin
      if (rx_valid && rx_ready) begin
        if (exp_bytes.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rx: got byte 0x%02h, expected no byte", rx_data);
        end else begin
          check("rx_data", int'(rx_data), int'(exp_bytes.pop_front()));
        end
      end
      if (parity_err || frame_err) begin
        if (exp_errs.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_err: got pe=%0b fe=%0b, expected no pulse", parity_err, frame_err);
        end else begin
          check("err_kind", int'({parity_err, frame_err}), int'(exp_errs.pop_front()));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rrst_n = 1'b0; enable = 1'b0; gpio_in = 1'b0; rx_ready = 1'b1; clr_status = 1'b0;
    wait_cycles(3);
    check("rst_rx_valid", int'(rx_valid), 0);
    check("rst_rx_data", int'(rx_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err_count", int'(err_count), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_perr", int'(parity_err), 0);
    check("rst_ferr", int'(frame_err), 0);
    rrst_n = 1'b1;
    enable = 1'b1;
    wait_cycles(2);

    // Good frame 0xA5 and its latency
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    tick(); check("a5_lat_t1", int'(rx_valid), 0);
    tick(); check("a5_lat_t2", int'(rx_valid), 0);
    tick(); check("a5_lat_t3", int'(rx_valid), 1);
    check("a5_data_t3", int'(rx_data), 'hA5);
    tick(); check("a5_lat_t4", int'(rx_valid), 0);
    check("a5_err_count", int'(err_count), exp_err_cnt);

    // Parity error then frame error, with pulse timing
    send_frame(8'h01, 1'b1, 1'b0, 1'b0);
    tick(); tick(); check("perr_t2", int'(parity_err), 0);
    tick(); check("perr_t3", int'(parity_err), 1);
    tick(); check("perr_t4", int'(parity_err), 0);
    check("perr_count", int'(err_count), exp_err_cnt);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    wait_cycles(4);
    check("ferr_count", int'(err_count), exp_err_cnt);

    // Error coinciding with clr_status leaves count at 1
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    exp_err_cnt = 1;
    tick();
    check("clr_coinc_count", int'(err_count), exp_err_cnt);
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    exp_err_cnt = 0;
    check("clr_count", int'(err_count), exp_err_cnt);

    // 256 erroneous frames saturate the counter
    for (int i = 0; i < 256; i++) begin
      logic sb;
      sb = 1'($urandom_range(0, 1));
      send_frame(8'($urandom), 1'b1, sb, 1'b0);
    end
    wait_cycles(4);
    check("sat_count", int'(err_count), exp_err_cnt);
    check("sat_model", exp_err_cnt, 255);

    // Overflow with a stalled consumer
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    exp_err_cnt = 0;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0, 1'b0);
    wait_cycles(4);
    check("ovf_set", int'(overflow), int'(exp_ovf));
    check("ovf_head_valid", int'(rx_valid), 1);
    check("ovf_head_stable", int'(rx_data), 'h11);
    rx_ready = 1'b1;
    wait_cycles(4);
    check("ovf_drain_q", exp_bytes.size(), 0);
    check("ovf_drain_valid", int'(rx_valid), 0);
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    exp_ovf = 1'b0;
    check("ovf_cleared", int'(overflow), 0);

    // Pop coinciding with the third push: no overflow
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    wait_cycles(2);
    check("coinc_no_ovf", int'(overflow), int'(exp_ovf));
    check("coinc_head", int'(rx_data), 'h22);
    rx_ready = 1'b1;
    wait_cycles(4);
    check("coinc_drain_q", exp_bytes.size(), 0);

    // Drop enable mid-frame
    send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b0);
    check("en_busy_before", int'(busy), 1);
    enable = 1'b0;
    tick();
    check("en_busy_after", int'(busy), 0);
    wait_cycles(5);
    check("en_err_count", int'(err_count), exp_err_cnt);
    enable = 1'b1;
    wait_cycles(2);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    wait_cycles(5);
    check("en_5a_q", exp_bytes.size(), 0);

    // Asynchronous reset mid-DATA with one byte buffered
    rx_ready = 1'b0;
    send_frame(8'h77, 1'b0, 1'b0, 1'b0);
    wait_cycles(4);
    check("rst2_buffered", int'(rx_valid), 1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #2;
    rrst_n = 1'b0;
    #1;
    exp_bytes.delete(); exp_errs.delete(); exp_err_cnt = 0; exp_ovf = 1'b0;
    check("rst2_rx_valid", int'(rx_valid), 0);
    check("rst2_rx_data", int'(rx_data), 0);
    check("rst2_busy", int'(busy), 0);
    check("rst2_err_count", int'(err_count), 0);
    check("rst2_overflow", int'(overflow), 0);
    gpio_in = 1'b0;
    tick(); tick();
    rrst_n = 1'b1;
    rx_ready = 1'b1;
    tick();
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    wait_cycles(5);
    check("rst2_ff_q", exp_bytes.size(), 0);

    // Randomized frames with random corruption and idle gaps
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    exp_err_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      int kind;
      int gap;
      kind = int'($urandom_range(0, 5));
      send_frame(8'($urandom), kind == 3 || kind == 5, 1'(kind >= 4), 1'b0);
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) send_bit(1'b0);
    end
    wait_cycles(6);
    check("rand_err_count", int'(err_count), exp_err_cnt);
    check("rand_bytes_q", exp_bytes.size(), 0);
    check("rand_errs_q", exp_errs.size(), 0);
    check("rand_overflow", int'(overflow), int'(exp_ovf));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpio_rx_deframer.md
# gpio_rx_deframer

Receive-side companion to the serial GPIO pin logic. It samples the serial GPIO input pin on rclk, one bit per cycle, and recovers framed bytes (start, 8 data MSB-first, even parity, stop). It checks parity and framing, then delivers good bytes through a 2-entry valid/ready output buffer to the rx FIFO write path. It also keeps sticky overflow and saturating error status for software.

## Interface
Parameters:
- SYNC_STAGES, 2, number of input synchronizer flops on gpio_in (minimum 2).
- BUF_DEPTH, 2, output buffer entries (fixed at 2; not to be changed).

Ports:
- rclk  input  1  clock; reset rrst_n, asynchronous, active-low; clock rclk.
- rrst_n  input  1  asynchronous active-low reset.
- enable  input  1  1 = receiver active; 0 = FSM held in IDLE.
- gpio_in  input  1  raw serial pin, asynchronous to rclk.
- rx_data  output  8  head-of-buffer byte.
- rx_valid  output  1  rx_data valid.
- rx_ready  input  1  consumer accepts when rx_valid && rx_ready.
- parity_err  output  1  one-cycle pulse: frame dropped, bad parity.
- frame_err  output  1  one-cycle pulse: frame dropped, stop bit was 1.
- overflow  output  1  sticky: a good byte was dropped because the buffer was full.
- clr_status  input  1  synchronous clear of overflow and err_count.
- err_count  output  8  saturating count of parity plus frame errors.
- busy  output  1  FSM not in IDLE.

## Operation
- gpio_in passes through a SYNC_STAGES flop chain. The FSM sees only the synchronized bit s.
- Frame format: start=1, D7..D0, P, stop=0. Line idle = 0. Even parity: popcount(D)+P is even.
- FSM states:
  - IDLE: if enable && s==1, go to DATA with bitcnt=0.
  - DATA: shift s into shreg LSB-side, so D7 ends in bit 7. bitcnt++. After bitcnt==7, go to PARITY.
  - PARITY: latch s as P, go to STOP.
  - STOP:
    - If s==0 and parity is OK, push shreg and raise no error.
    - If s==1, pulse frame_err and discard. Frame error has priority over parity error.
    - Else (parity bad), pulse parity_err and discard.
    - Next state is IDLE. Back-to-back frames are allowed: a start bit sampled in the cycle after STOP is accepted.
- enable deasserted in any state forces IDLE on the next edge. The partial frame is discarded with no error pulse. Buffer contents are kept.
- Output buffer: 2-entry FIFO.
  - Push when full and no pop in the same cycle: byte dropped, overflow set.
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - Pop when empty: ignored.
- err_count increments on each parity_err or frame_err pulse and saturates at 255.
- clr_status clears overflow and err_count. If an event occurs in the same cycle as clr_status, the result is overflow=1 or err_count=1 (the new event wins).
- Reset values: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overflow=0, err_count=0, busy=0. The FSM is in IDLE, the synchronizer is all 0, and the buffer is empty.
- Reset asserted mid-frame or with buffer contents: everything is discarded immediately, asynchronously.

## Timing
- A bit present on gpio_in at edge t is seen by the FSM at edge t+SYNC_STAGES.
- Stop bit sampled on gpio_in at edge t means:
  - rx_valid is high after edge t+SYNC_STAGES+1, provided the buffer was empty; or
  - the error pulse is high for exactly the cycle after edge t+SYNC_STAGES+1.
- A frame occupies 11 cycles. Sustained throughput is 1 byte per 11 cycles when rx_ready is held high.
- rx_data and rx_valid are registered. rx_data stays stable while rx_valid && !rx_ready.
- Pop is effective at the edge where rx_valid && rx_ready. The next entry appears in the following cycle.
- busy is high from the edge entering DATA through the edge leaving STOP.

## Test plan
- Reset, then drive frame 0xA5 (1,1,0,1,0,0,1,0,1,P=0,0) with rx_ready=1. Expect rx_data=0xA5 and rx_valid for 1 cycle, 3 edges after the stop bit; err_count=0.
- Frame 0x01 with P=0 (bad) → parity_err one pulse, no rx_valid, err_count=1. Next frame 0x3C with stop=1 → frame_err pulse, err_count=2. Then clr_status → err_count=0.
- Send 256 bad-parity frames → err_count saturates at 255.
- Hold rx_ready=0 and send 0x11, 0x22, 0x33 back-to-back → buffer holds 0x11, 0x22 and overflow=1. Release rx_ready → pops in order 0x11 then 0x22 only. Repeat with rx_ready pulsed exactly on the third push cycle → no overflow.
- Drop enable after 4 data bits → busy falls next cycle, no pulse, no push. A subsequent full frame 0x5A is received correctly.
- Assert rrst_n mid-DATA with 1 byte buffered → all outputs at reset values immediately. After release, frame 0xFF (P=0) is received correctly.
